// File: rtl/neopix_frame_scheduler_pkg.sv
// Shared constants, state encodings and sizing helpers for the NeoPixel frame scheduler.
package neopix_pkg;

  localparam int unsigned DEF_NUM_LEDS     = 8;
  localparam int unsigned DEF_SYSTEM_CLOCK = 50000000;
  localparam int unsigned DEF_LATCH_US     = 300;
  localparam int unsigned DEF_REFRESH_HZ   = 30;
  localparam int unsigned DEF_BUSY_TIMEOUT = 16;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_START     = 3'd1;
  localparam state_t ST_WAIT_BUSY = 3'd2;
  localparam state_t ST_BUSY      = 3'd3;
  localparam state_t ST_LATCH     = 3'd4;

  // Wide enough to hold a count equal to NUM_LEDS.
  function automatic int unsigned led_w_f(input int unsigned num_leds);
    return $clog2(num_leds) + 1;
  endfunction

  function automatic int unsigned latch_cycles_f(input int unsigned sys_clk, input int unsigned us);
    int unsigned c;
    c = sys_clk / 1000000 * us;
    return (c == 0) ? 1 : c;
  endfunction

  // A disabled refresh still needs a legal counter reload value.
  function automatic int unsigned refresh_cycles_f(input int unsigned sys_clk, input int unsigned hz);
    return (hz == 0) ? 1 : sys_clk / hz;
  endfunction

  // Bits needed to hold values 0..n-1.
  function automatic int unsigned cnt_w_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/neopix_frame_scheduler_if.sv
// Bundle between the scheduler, the SPI frame writer and the ws2812 serialiser.
interface neopix_frame_scheduler_if #(
  parameter int unsigned LED_W = neopix_pkg::led_w_f(neopix_pkg::DEF_NUM_LEDS)
);
  logic             frame_done_i;
  logic [LED_W-1:0] frame_len_i;
  logic             refresh_en_i;
  logic             ws_busy_i;
  logic             ws_start_o;
  logic             disp_bank_o;
  logic             wr_bank_o;
  logic [LED_W-1:0] led_count_o;
  logic             frame_drop_o;
  logic             timeout_o;
  logic             idle_o;

  modport master (
    output frame_done_i, frame_len_i, refresh_en_i, ws_busy_i,
    input  ws_start_o, disp_bank_o, wr_bank_o, led_count_o, frame_drop_o, timeout_o, idle_o
  );

  modport slave (
    input  frame_done_i, frame_len_i, refresh_en_i, ws_busy_i,
    output ws_start_o, disp_bank_o, wr_bank_o, led_count_o, frame_drop_o, timeout_o, idle_o
  );
endinterface

// File: rtl/neopix_frame_scheduler_dn_counter.sv
// Loadable down-counter that saturates at zero; zero_c flags the terminal count.
module neopix_dn_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/neopix_frame_scheduler.sv
// Ping-pong bank owner and transmit sequencer for the ws2812 serialiser.
module neopix_frame_scheduler
  import neopix_pkg::*;
#(
  parameter int unsigned NUM_LEDS     = DEF_NUM_LEDS,
  parameter int unsigned SYSTEM_CLOCK = DEF_SYSTEM_CLOCK,
  parameter int unsigned LATCH_US     = DEF_LATCH_US,
  parameter int unsigned REFRESH_HZ   = DEF_REFRESH_HZ,
  parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input logic                     clk_i,
  input logic                     reset_n_i,
  neopix_frame_scheduler_if.slave bus
);

  localparam int unsigned LED_W          = led_w_f(NUM_LEDS);
  localparam int unsigned LATCH_CYCLES   = latch_cycles_f(SYSTEM_CLOCK, LATCH_US);
  localparam int unsigned REFRESH_CYCLES = refresh_cycles_f(SYSTEM_CLOCK, REFRESH_HZ);
  localparam int unsigned LATCH_CNT_W    = cnt_w_f(LATCH_CYCLES);
  localparam int unsigned REFRESH_CNT_W  = cnt_w_f(REFRESH_CYCLES);
  localparam int unsigned WAIT_CNT_W     = cnt_w_f(BUSY_TIMEOUT);

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [LED_W-1:0]       pend_len_q, pend_len_d;
  logic                   valid_q, valid_d;
  logic                   wr_bank_q, wr_bank_d;
  logic                   disp_bank_q, disp_bank_d;
  logic [LED_W-1:0]       led_count_q, led_count_d;
  logic                   ws_start_q, ws_start_d;
  logic                   frame_drop_q, frame_drop_d;
  logic                   timeout_q, timeout_d;
  logic                   idle_q, idle_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic             latch_load, latch_dec, latch_zero;
  logic             refresh_load, refresh_zero;
  logic [LED_W-1:0] len_raw, len_clip;
  logic             capture, pend_eff;
  logic [LED_W-1:0] pend_len_eff;

  neopix_dn_counter #(.W(LATCH_CNT_W)) u_latch_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (latch_load),
    .load_val_i (LATCH_CNT_W'(LATCH_CYCLES - 1)),
    .dec_i      (latch_dec),
    .zero_c     (latch_zero)
  );

  neopix_dn_counter #(.W(REFRESH_CNT_W)) u_refresh_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (refresh_load),
    .load_val_i (REFRESH_CNT_W'(REFRESH_CYCLES - 1)),
    .dec_i      (1'b1),
    .zero_c     (refresh_zero)
  );

  // Frame capture is folded in combinationally so an IDLE frame starts next cycle.
  always_comb begin
    len_raw      = LED_W'(bus.frame_len_i);
    len_clip     = (len_raw > LED_W'(NUM_LEDS)) ? LED_W'(NUM_LEDS) : len_raw;
    capture      = bus.frame_done_i && (len_clip != '0);
    pend_eff     = pending_q || capture;
    pend_len_eff = capture ? len_clip : pend_len_q;
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    pending_d    = pend_eff;
    pend_len_d   = pend_len_eff;
    valid_d      = valid_q;
    wr_bank_d    = wr_bank_q;
    disp_bank_d  = disp_bank_q;
    led_count_d  = led_count_q;
    frame_drop_d = capture && pending_q;
    timeout_d    = 1'b0;
    wait_cnt_d   = wait_cnt_q;
    latch_load   = 1'b0;
    latch_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_eff && latch_zero) begin
          state_d     = ST_START;
          disp_bank_d = wr_bank_q;
          wr_bank_d   = ~wr_bank_q;
          led_count_d = pend_len_eff;
          pending_d   = 1'b0;
          valid_d     = 1'b1;
        end else if ((REFRESH_HZ > 0) && bus.refresh_en_i && valid_q && refresh_zero) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (bus.ws_busy_i) begin
          state_d = ST_BUSY;
        end else if (wait_cnt_q == WAIT_CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_LATCH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (!bus.ws_busy_i) begin
          latch_load = 1'b1;
          state_d    = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (latch_zero) begin
          state_d = ST_IDLE;
        end else begin
          latch_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    refresh_load = (state_q == ST_IDLE) && (state_d == ST_START);
    ws_start_d   = refresh_load;
    idle_d       = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      pend_len_q   <= '0;
      valid_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      disp_bank_q  <= 1'b1;
      led_count_q  <= '0;
      ws_start_q   <= 1'b0;
      frame_drop_q <= 1'b0;
      timeout_q    <= 1'b0;
      idle_q       <= 1'b1;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pend_len_q   <= pend_len_d;
      valid_q      <= valid_d;
      wr_bank_q    <= wr_bank_d;
      disp_bank_q  <= disp_bank_d;
      led_count_q  <= led_count_d;
      ws_start_q   <= ws_start_d;
      frame_drop_q <= frame_drop_d;
      timeout_q    <= timeout_d;
      idle_q       <= idle_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.ws_start_o   = ws_start_q;
  assign bus.disp_bank_o  = disp_bank_q;
  assign bus.wr_bank_o    = wr_bank_q;
  assign bus.led_count_o  = led_count_q;
  assign bus.frame_drop_o = frame_drop_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.idle_o       = idle_q;

endmodule

// File: tb/tb_neopix_frame_scheduler.sv
// Directed bench for the NeoPixel frame scheduler: 10-cycle latch gap, 100-cycle refresh.
module tb_neopix_frame_scheduler;

  localparam int unsigned NUM_LEDS     = 8;
  localparam int unsigned SYSTEM_CLOCK = 1000000;
  localparam int unsigned LATCH_US     = 10;
  localparam int unsigned REFRESH_HZ   = 10000;
  localparam int unsigned BUSY_TIMEOUT = 16;
  localparam int unsigned LED_W        = 4;

  logic clk_i     = 1'b0;
  logic reset_n_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  neopix_frame_scheduler_if #(.LED_W(LED_W)) bus ();

  neopix_frame_scheduler #(
    .NUM_LEDS     (NUM_LEDS),
    .SYSTEM_CLOCK (SYSTEM_CLOCK),
    .LATCH_US     (LATCH_US),
    .REFRESH_HZ   (REFRESH_HZ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input int len);
    bus.frame_done_i = 1'b1;
    bus.frame_len_i  = LED_W'(len);
    tick();
    bus.frame_done_i = 1'b0;
    bus.frame_len_i  = '0;
  endtask

  // Called in the cycle ws_start_o is seen: serialiser goes busy next cycle for b cycles.
  task automatic run_tx(input int b);
    tick();
    bus.ws_busy_i = 1'b1;
    repeat (b) tick();
    bus.ws_busy_i = 1'b0;
  endtask

  task automatic wait_start(input int max, output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < max) begin
      tick();
      n++;
      if (bus.ws_start_o) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;

    bus.frame_done_i = 1'b0;
    bus.frame_len_i  = '0;
    bus.refresh_en_i = 1'b0;
    bus.ws_busy_i    = 1'b0;

    #1 reset_n_i = 1'b0;
    repeat (2) tick();
    check_eq("rst_ws_start", bus.ws_start_o, 0);
    check_eq("rst_disp_bank", bus.disp_bank_o, 1);
    check_eq("rst_wr_bank", bus.wr_bank_o, 0);
    check_eq("rst_led_count", bus.led_count_o, 0);
    check_eq("rst_frame_drop", bus.frame_drop_o, 0);
    check_eq("rst_timeout", bus.timeout_o, 0);
    check_eq("rst_idle", bus.idle_o, 1);
    reset_n_i = 1'b1;
    repeat (2) tick();
    check_eq("post_rst_no_start", bus.ws_start_o, 0);

    // Frame in IDLE starts on the very next cycle with swapped banks.
    send_frame(5);
    check_eq("f5_start", bus.ws_start_o, 1);
    check_eq("f5_disp_bank", bus.disp_bank_o, 0);
    check_eq("f5_wr_bank", bus.wr_bank_o, 1);
    check_eq("f5_led_count", bus.led_count_o, 5);
    check_eq("f5_idle_low", bus.idle_o, 0);

    // Busy for 40 cycles with a second frame arriving mid-transmission.
    tick();
    check_eq("start_one_cycle", bus.ws_start_o, 0);
    bus.ws_busy_i = 1'b1;
    repeat (10) tick();
    send_frame(3);
    check_eq("busy_disp_stable", bus.disp_bank_o, 0);
    check_eq("busy_led_stable", bus.led_count_o, 5);
    check_eq("busy_no_drop", bus.frame_drop_o, 0);
    repeat (29) tick();
    bus.ws_busy_i = 1'b0;
    wait_start(40, n, found);
    check_eq("f3_started", found, 1);
    check_eq("f3_latch_delay", n, 12);
    check_eq("f3_disp_bank", bus.disp_bank_o, 1);
    check_eq("f3_wr_bank", bus.wr_bank_o, 0);
    check_eq("f3_led_count", bus.led_count_o, 3);

    // Two frames during busy: the newer replaces the queued one.
    tick();
    bus.ws_busy_i = 1'b1;
    repeat (3) tick();
    send_frame(4);
    check_eq("f4_no_drop", bus.frame_drop_o, 0);
    tick();
    send_frame(7);
    check_eq("f7_drop_pulse", bus.frame_drop_o, 1);
    tick();
    check_eq("drop_one_cycle", bus.frame_drop_o, 0);
    repeat (5) tick();
    bus.ws_busy_i = 1'b0;
    wait_start(40, n, found);
    check_eq("f7_started", found, 1);
    check_eq("f7_latch_delay", n, 12);
    check_eq("f7_led_count", bus.led_count_o, 7);
    check_eq("f7_disp_bank", bus.disp_bank_o, 0);
    check_eq("f7_wr_bank", bus.wr_bank_o, 1);
    run_tx(5);
    wait_start(60, n, found);
    check_eq("f7_single_start", found, 0);
    check_eq("f7_idle", bus.idle_o, 1);

    // Zero-length frame is ignored; oversize frame clamps to NUM_LEDS.
    send_frame(0);
    check_eq("f0_no_start", bus.ws_start_o, 0);
    check_eq("f0_no_drop", bus.frame_drop_o, 0);
    tick();
    check_eq("f0_still_idle", bus.idle_o, 1);
    check_eq("f0_no_late_start", bus.ws_start_o, 0);
    send_frame(12);
    check_eq("f12_start", bus.ws_start_o, 1);
    check_eq("f12_led_clamp", bus.led_count_o, 8);
    check_eq("f12_disp_bank", bus.disp_bank_o, 1);
    check_eq("f12_wr_bank", bus.wr_bank_o, 0);

    // Periodic refresh every 100 cycles without a bank swap.
    bus.refresh_en_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_tx(5);
      wait_start(200, n, found);
      check_eq("refresh_started", found, 1);
      check_eq("refresh_period", n + 6, 100);
      check_eq("refresh_disp_bank", bus.disp_bank_o, 1);
      check_eq("refresh_wr_bank", bus.wr_bank_o, 0);
      check_eq("refresh_led_count", bus.led_count_o, 8);
    end
    bus.refresh_en_i = 1'b0;
    run_tx(5);
    wait_start(250, n, found);
    check_eq("refresh_off_no_start", found, 0);

    // Serialiser never asserts busy: timeout after 16 waiting cycles.
    send_frame(2);
    check_eq("f2_start", bus.ws_start_o, 1);
    check_eq("f2_led_count", bus.led_count_o, 2);
    check_eq("f2_disp_bank", bus.disp_bank_o, 0);
    n = 0;
    while (!bus.timeout_o && n < 40) begin
      tick();
      n++;
    end
    check_eq("timeout_seen", bus.timeout_o, 1);
    check_eq("timeout_delay", n, 17);
    tick();
    check_eq("timeout_one_cycle", bus.timeout_o, 0);
    check_eq("timeout_back_idle", bus.idle_o, 1);
    check_eq("timeout_no_restart", bus.ws_start_o, 0);

    // Reset asserted mid-transmission clears outputs without waiting for a clock.
    send_frame(6);
    check_eq("f6_start", bus.ws_start_o, 1);
    check_eq("f6_disp_bank", bus.disp_bank_o, 1);
    tick();
    bus.ws_busy_i = 1'b1;
    repeat (3) tick();
    check_eq("f6_busy_not_idle", bus.idle_o, 0);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("arst_disp_bank", bus.disp_bank_o, 1);
    check_eq("arst_wr_bank", bus.wr_bank_o, 0);
    check_eq("arst_led_count", bus.led_count_o, 0);
    check_eq("arst_idle", bus.idle_o, 1);
    check_eq("arst_ws_start", bus.ws_start_o, 0);
    bus.ws_busy_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    wait_start(20, n, found);
    check_eq("arst_no_start", found, 0);
    check_eq("arst_idle_after", bus.idle_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
